store_formatter: RTL and testbench
==================================

# store_formatter

Store-path data formatter. It is the write-side counterpart of the load-path sign extension unit. It accepts one store request (address, up to 64-bit register data, access size) and emits one or two word-wide memory write beats with byte enables over a valid/ready handshake. It sits between the execute stage's store port and the data memory write port. Doublewords, and (optionally) word-crossing misaligned stores, are split into two beats.

## Interface
- ADDR_W, 32, address width (≥3)
- CLK  in  1  clock, rising edge
- CLR  in  1  reset, asynchronous, active-low
- req_valid  in  1  store request valid
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- addr  in  ADDR_W  byte address of store
- D  in  64  store data; [31:0] used for byte/half/word, [63:0] for doubleword
- dataSize  in  2  00 byte, 01 half, 10 word, 11 doubleword
- mem_valid  out  1  write beat valid
- mem_ready  in  1  memory accepts beat when mem_valid & mem_ready
- mem_addr  out  ADDR_W  word-aligned beat address (bits [1:0] = 0)
- mem_data  out  32  beat write data
- mem_be  out  4  byte enables, bit i = lane i (data[8i+7:8i])
- mem_last  out  1  final beat of current request
- err  out  1  one-cycle pulse: request rejected (misaligned), no beats issued

## Operation
- States: IDLE, BEAT0, BEAT1, ERR. req_ready = (state == IDLE).
- Accept in IDLE on req_valid. Register addr, D, dataSize. Next state is BEAT0, or ERR if the request is illegal.
- Byte/half/word lane rule: sz mask m = 0001/0011/1111; S = {32'b0, D[31:0]} << (8·addr[1:0]); M = {4'b0, m} << addr[1:0].
  - beat0: data S[31:0], be M[3:0], addr {addr[ADDR_W-1:2], 2'b00}.
  - beat1 exists iff M[7:4] ≠ 0: data S[63:32], be M[7:4], addr = beat0 addr + 4.
- Doubleword: beat0 data D[31:0], be 1111; beat1 data D[63:32], be 1111, addr + 4.
- Lanes with be = 0 drive data 0.
- Address +4 wraps modulo 2^ADDR_W (e.g. 0xFFFFFFFC → 0x00000000).
- Alignment legality:
  - Doubleword with addr[1:0] ≠ 0 is always illegal.
  - Other sizes: see Configuration.
- ERR: err = 1 for exactly one cycle, mem_valid = 0, then return to IDLE.
- BEAT0 → BEAT1 on mem_ready if a second beat exists; otherwise BEAT0 → IDLE. BEAT1 → IDLE on mem_ready.
- req_valid during BEAT0/BEAT1/ERR is ignored. The requester holds it.

## Timing
- All outputs are registered. Reset values: req_ready 1, mem_valid 0, mem_addr 0, mem_data 0, mem_be 0, mem_last 0, err 0, state IDLE.
- Accept at edge N → mem_valid (or err) high in cycle N+1.
- mem_valid, mem_addr, mem_data, mem_be and mem_last are held stable while mem_valid & !mem_ready.
- Back-to-back beats: beat1 is presented the cycle after beat0 handshake.
- Completing the final handshake at edge K gives req_ready = 1 in cycle K+1.
- Throughput is one request per (beats + 1) cycles with mem_ready tied high.
- mem_last = 1 on the only beat of single-beat requests and on beat1 of split requests.
- CLR low at any time, including mid-request: all outputs immediately take reset values and the pending request is discarded. After CLR release, the first acceptance is possible on the next rising edge.

## Configuration
- MISALIGN_SPLIT_EN defined: half and word at any addr[1:0] are legal.
  - Stores that fit in one word (e.g. half at 01) issue one beat.
  - Stores that cross a word issue two beats per the lane rule.
- MISALIGN_SPLIT_EN undefined: natural alignment is required. Half with addr[0] = 1, or word with addr[1:0] ≠ 0, goes to ERR. Every legal byte/half/word store is exactly one beat.

## Test plan
- Byte store, addr 0x1003, D = 0xAB, mem_ready = 1 → one beat: addr 0x1000, be 1000, data 0xAB000000, last 1; req_ready back high 2 cycles after accept.
- Doubleword store, addr 0x2000, D = 0x1122334455667788, mem_ready low 3 cycles on beat0.
  - beat0: 0x2000 / 0x55667788 / 1111 / last 0, stable across the stall.
  - beat1: 0x2004 / 0x11223344 / 1111 / last 1.
- Half store, addr 0x3003, D = 0xBEEF:
  - macro on → beat0 0x3000 be 1000 data 0xEF000000; beat1 0x3004 be 0001 data 0x000000BE.
  - macro off → err pulse 1 cycle, mem_valid never high.
- Word store, addr 0xFFFFFFFE, D = 0xCAFEF00D, macro on → beat0 0xFFFFFFFC be 1100 data 0xF00D0000; beat1 0x00000000 be 0011 data 0x0000CAFE.
- Doubleword at 0x4004 → accepted; beat0 0x4004, beat1 0x4008. Doubleword at 0x4002 → err pulse in both configurations.
- CLR driven low while beat1 waits on mem_ready → mem_valid/mem_be/mem_last drop to 0 asynchronously. After release, req_ready = 1 and a new byte store completes normally.

Source files
------------

// File: rtl/store_formatter.sv
// store_formatter
//   Store-path data formatter. Takes one store request (address, up to 64-bit
//   data, access size) and emits one or two word-wide write beats with byte
//   enables. Doublewords always split into two beats; word-crossing half/word
//   stores split into two beats when misaligned support is built in.
//
//   Build option: MISALIGN_SPLIT_EN
//     defined   - half/word stores at any byte offset are legal
//     undefined - natural alignment required, misaligned half/word -> err
//
//   Ports
//     CLK, CLR         clock (rising edge), async active-low reset
//     req_valid/ready  store request handshake (ready only in IDLE)
//     addr, D          store byte address and data
//     dataSize         00 byte, 01 half, 10 word, 11 doubleword
//     mem_valid/ready  write beat handshake
//     mem_addr         word-aligned beat address
//     mem_data, mem_be beat data and byte enables (unused lanes drive 0)
//     mem_last         final beat of the request
//     err              one-cycle pulse for a rejected (misaligned) request
//
//   state  | meaning
//   IDLE   | ready for a request
//   BEAT0  | first (or only) beat presented
//   BEAT1  | second beat presented
//   ERR    | err pulse, no beats issued
module store_formatter #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       D,
    input  logic [1:0]        dataSize,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic [3:0]        mem_be,
    output logic              mem_last,
    output logic              err
);

    typedef enum logic [1:0] {ST_IDLE, ST_BEAT0, ST_BEAT1, ST_ERR} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_b1_addr;
    logic [31:0]       r_b1_data;
    logic [3:0]        r_b1_be;
    logic              r_has_b1;

    logic              w_ready_nxt, w_valid_nxt, w_last_nxt, w_err_nxt;
    logic [ADDR_W-1:0] w_addr_nxt, w_b1_addr_nxt;
    logic [31:0]       w_data_nxt, w_b1_data_nxt;
    logic [3:0]        w_be_nxt, w_b1_be_nxt;
    logic              w_has_b1_nxt;

    // Request decode, evaluated on the incoming request fields
    logic [3:0]        w_sz_msk;
    logic [63:0]       w_lane_data;
    logic [7:0]        w_lane_be;
    logic              w_is_dw, w_illegal;
    logic [ADDR_W-1:0] w_base;
    logic [31:0]       w_req_b0_data, w_req_b1_data;
    logic [3:0]        w_req_b0_be, w_req_b1_be;
    logic              w_req_has_b1;

    function automatic logic [31:0] be2mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    always_comb begin
        case (dataSize)
            2'b00:   w_sz_msk = 4'b0001;
            2'b01:   w_sz_msk = 4'b0011;
            default: w_sz_msk = 4'b1111;
        endcase
        w_is_dw     = (dataSize == 2'b11);
        w_lane_data = {32'b0, D[31:0]} << {addr[1:0], 3'b000};
        w_lane_be   = {4'b0, w_sz_msk} << addr[1:0];
        w_base      = {addr[ADDR_W-1:2], 2'b00};

        if (w_is_dw) begin
            w_req_b0_data = D[31:0];
            w_req_b1_data = D[63:32];
            w_req_b0_be   = 4'b1111;
            w_req_b1_be   = 4'b1111;
            w_req_has_b1  = 1'b1;
        end else begin
            // Bytes of D beyond the access size must not leak into lanes
            w_req_b0_data = w_lane_data[31:0]  & be2mask(w_lane_be[3:0]);
            w_req_b1_data = w_lane_data[63:32] & be2mask(w_lane_be[7:4]);
            w_req_b0_be   = w_lane_be[3:0];
            w_req_b1_be   = w_lane_be[7:4];
            w_req_has_b1  = |w_lane_be[7:4];
        end

`ifdef MISALIGN_SPLIT_EN
        w_illegal = w_is_dw && (addr[1:0] != 2'b00);
`else
        w_illegal = (w_is_dw && (addr[1:0] != 2'b00))
                 || ((dataSize == 2'b01) && addr[0])
                 || ((dataSize == 2'b10) && (addr[1:0] != 2'b00));
`endif
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ready_nxt   = req_ready;
        w_valid_nxt   = mem_valid;
        w_addr_nxt    = mem_addr;
        w_data_nxt    = mem_data;
        w_be_nxt      = mem_be;
        w_last_nxt    = mem_last;
        w_err_nxt     = 1'b0;
        w_b1_addr_nxt = r_b1_addr;
        w_b1_data_nxt = r_b1_data;
        w_b1_be_nxt   = r_b1_be;
        w_has_b1_nxt  = r_has_b1;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_ready_nxt = 1'b0;
                    if (w_illegal) begin
                        w_state_nxt = ST_ERR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt   = ST_BEAT0;
                        w_valid_nxt   = 1'b1;
                        w_addr_nxt    = w_base;
                        w_data_nxt    = w_req_b0_data;
                        w_be_nxt      = w_req_b0_be;
                        w_last_nxt    = !w_req_has_b1;
                        w_b1_addr_nxt = w_base + ADDR_W'(4);   // wraps naturally
                        w_b1_data_nxt = w_req_b1_data;
                        w_b1_be_nxt   = w_req_b1_be;
                        w_has_b1_nxt  = w_req_has_b1;
                    end
                end
            end
            ST_BEAT0: begin
                if (mem_ready) begin
                    if (r_has_b1) begin
                        w_state_nxt = ST_BEAT1;
                        w_addr_nxt  = r_b1_addr;
                        w_data_nxt  = r_b1_data;
                        w_be_nxt    = r_b1_be;
                        w_last_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_ready_nxt = 1'b1;
                        w_valid_nxt = 1'b0;
                        w_addr_nxt  = '0;
                        w_data_nxt  = '0;
                        w_be_nxt    = '0;
                        w_last_nxt  = 1'b0;
                    end
                end
            end
            ST_BEAT1: begin
                if (mem_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_ready_nxt = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_addr_nxt  = '0;
                    w_data_nxt  = '0;
                    w_be_nxt    = '0;
                    w_last_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state   <= ST_IDLE;
            req_ready <= 1'b1;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_be    <= '0;
            mem_last  <= 1'b0;
            err       <= 1'b0;
            r_b1_addr <= '0;
            r_b1_data <= '0;
            r_b1_be   <= '0;
            r_has_b1  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            req_ready <= w_ready_nxt;
            mem_valid <= w_valid_nxt;
            mem_addr  <= w_addr_nxt;
            mem_data  <= w_data_nxt;
            mem_be    <= w_be_nxt;
            mem_last  <= w_last_nxt;
            err       <= w_err_nxt;
            r_b1_addr <= w_b1_addr_nxt;
            r_b1_data <= w_b1_data_nxt;
            r_b1_be   <= w_b1_be_nxt;
            r_has_b1  <= w_has_b1_nxt;
        end
    end

endmodule

// File: tb/tb_store_formatter.sv
// Directed bench for store_formatter. Expected values are hand-computed.
// Works with MISALIGN_SPLIT_EN defined or undefined.
module tb_store_formatter;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [63:0] D;
    logic [1:0]  dataSize;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic        mem_last;
    logic        err;

    int total = 0;
    int bad   = 0;

    store_formatter #(.ADDR_W(32)) dut (
        .CLK(CLK), .CLR(CLR),
        .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .D(D), .dataSize(dataSize),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be),
        .mem_last(mem_last), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic last);
        chk({tag, ".valid"}, 64'(mem_valid), 64'd1);
        chk({tag, ".addr"},  64'(mem_addr),  64'(a));
        chk({tag, ".data"},  64'(mem_data),  64'(d));
        chk({tag, ".be"},    64'(mem_be),    64'(be));
        chk({tag, ".last"},  64'(mem_last),  64'(last));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 64'(mem_valid), 64'd0);
        chk({tag, ".ready"}, 64'(req_ready), 64'd1);
        chk({tag, ".err"},   64'(err),       64'd0);
    endtask

    task automatic chk_err(input string tag);
        chk({tag, ".err"},   64'(err),       64'd1);
        chk({tag, ".valid"}, 64'(mem_valid), 64'd0);
        tick();
        chk({tag, ".err_gone"}, 64'(err),    64'd0);
        chk_idle({tag, ".after"});
    endtask

    // Present a request for one edge, then drop req_valid
    task automatic issue(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz);
        addr = a; D = d; dataSize = sz; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        CLR = 1'b0; req_valid = 1'b0; mem_ready = 1'b0;
        addr = '0; D = '0; dataSize = '0;
        #12;
        chk("rst.ready", 64'(req_ready), 64'd1);
        chk("rst.valid", 64'(mem_valid), 64'd0);
        chk("rst.addr",  64'(mem_addr),  64'd0);
        chk("rst.data",  64'(mem_data),  64'd0);
        chk("rst.be",    64'(mem_be),    64'd0);
        chk("rst.last",  64'(mem_last),  64'd0);
        chk("rst.err",   64'(err),       64'd0);
        CLR = 1'b1;
        tick();

        // Byte at 0x1003
        mem_ready = 1'b1;
        issue(32'h1003, 64'hAB, 2'b00);
        chk_beat("byte", 32'h1000, 32'hAB000000, 4'b1000, 1'b1);
        chk("byte.ready_busy", 64'(req_ready), 64'd0);
        tick();
        chk_idle("byte.done");

        // Byte at 0x1001 with upper data bits set: only lane 1 carries data
        issue(32'h1001, 64'h12345678, 2'b00);
        chk_beat("bytemask", 32'h1000, 32'h00007800, 4'b0010, 1'b1);
        tick();
        chk_idle("bytemask.done");

        // Doubleword with a three-cycle stall on beat0
        mem_ready = 1'b0;
        issue(32'h2000, 64'h1122334455667788, 2'b11);
        chk_beat("dw.b0", 32'h2000, 32'h55667788, 4'b1111, 1'b0);
        tick();
        chk_beat("dw.b0s1", 32'h2000, 32'h55667788, 4'b1111, 1'b0);
        tick();
        chk_beat("dw.b0s2", 32'h2000, 32'h55667788, 4'b1111, 1'b0);
        mem_ready = 1'b1;
        tick();
        chk_beat("dw.b1", 32'h2004, 32'h11223344, 4'b1111, 1'b1);
        tick();
        chk_idle("dw.done");

        // Aligned half at 0x3002: single beat in both builds
        issue(32'h3002, 64'hBEEF, 2'b01);
        chk_beat("half2", 32'h3000, 32'hBEEF0000, 4'b1100, 1'b1);
        tick();
        chk_idle("half2.done");

        // Half at 0x3003 crosses a word
        issue(32'h3003, 64'hBEEF, 2'b01);
`ifdef MISALIGN_SPLIT_EN
        chk_beat("half3.b0", 32'h3000, 32'hEF000000, 4'b1000, 1'b0);
        tick();
        chk_beat("half3.b1", 32'h3004, 32'h000000BE, 4'b0001, 1'b1);
        tick();
        chk_idle("half3.done");
`else
        chk_err("half3");
`endif

        // Word at 0xFFFFFFFE: beat1 address wraps
        issue(32'hFFFFFFFE, 64'hCAFEF00D, 2'b10);
`ifdef MISALIGN_SPLIT_EN
        chk_beat("wwrap.b0", 32'hFFFFFFFC, 32'hF00D0000, 4'b1100, 1'b0);
        tick();
        chk_beat("wwrap.b1", 32'h00000000, 32'h0000CAFE, 4'b0011, 1'b1);
        tick();
        chk_idle("wwrap.done");
`else
        chk_err("wwrap");
`endif

        // Doubleword at 0x4004 is legal; at 0x4002 always rejected
        issue(32'h4004, 64'hA5A5A5A5_5A5A5A5A, 2'b11);
        chk_beat("dw4.b0", 32'h4004, 32'h5A5A5A5A, 4'b1111, 1'b0);
        tick();
        chk_beat("dw4.b1", 32'h4008, 32'hA5A5A5A5, 4'b1111, 1'b1);
        tick();
        chk_idle("dw4.done");
        issue(32'h4002, 64'h0123456789ABCDEF, 2'b11);
        chk_err("dw2");

        // Reset while beat1 waits on mem_ready
        issue(32'h5000, 64'hDEADBEEF_01020304, 2'b11);
        chk_beat("clr.b0", 32'h5000, 32'h01020304, 4'b1111, 1'b0);
        tick();
        chk_beat("clr.b1", 32'h5004, 32'hDEADBEEF, 4'b1111, 1'b1);
        mem_ready = 1'b0;
        #2;
        CLR = 1'b0;
        #1;
        chk("clr.valid", 64'(mem_valid), 64'd0);
        chk("clr.be",    64'(mem_be),    64'd0);
        chk("clr.last",  64'(mem_last),  64'd0);
        chk("clr.ready", 64'(req_ready), 64'd1);
        #1;
        CLR = 1'b1;
        mem_ready = 1'b1;
        issue(32'h6002, 64'h5A, 2'b00);
        chk_beat("post", 32'h6000, 32'h005A0000, 4'b0100, 1'b1);
        tick();
        chk_idle("post.done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
